bidir_bus_ctrl: RTL and testbench
=================================

Name: bidir_bus_ctrl

Overview:
- Bus-side controller for the 5-bit shared bidirectional counter bus.
- Owns the direction signal, drives a load value onto the bus, then turns the bus around and samples the counter's output.
- Optionally checks the sampled values for a +1 sequence and reports the result to a host through a start/done handshake.
- Sits directly upstream of the counter: dir_en connects to the counter's en, and bidir connects to its bidir pin.

Parameters:
- WIDTH, 5, bus and counter width.
- RD_CYCLES, 8, number of checked samples per read window (minimum 2).
- TA_CYCLES, 1, idle turnaround cycles between direction changes (minimum 1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  host request; sampled in IDLE only.
- load_val  input  WIDTH  value written to the counter; captured on an accepted start.
- busy  output  1  high from the cycle after an accepted start until done.
- dir_en  output  1  to counter en: 0 = controller side owns the bus, 1 = counter drives.
- bidir  inout  WIDTH  shared bus; driven with the load register only when oe=1, otherwise high-Z.
- smp_data  output  WIDTH  last sampled bus value.
- smp_valid  output  1  one-cycle pulse per checked sample.
- done  output  1  one-cycle pulse at the end of a transaction.
- err  output  1  sticky sequence error; cleared on an accepted start.

Behaviour:
- Reset values: rst low asynchronously forces:
  - state=IDLE, oe=0 (bidir high-Z), dir_en=0, busy=0;
  - smp_data=0, smp_valid=0, done=0, err=0.
  - Reset mid-transaction abandons it; no done pulse is generated.
- Internal oe is registered, never combinational. dir_en=1 and oe=1 must never both be true in any cycle.
- States and transitions:
  - IDLE: oe=0, dir_en=0. start=1 -> capture load_val, clear err, go to DRIVE.
  - DRIVE, exactly 1 cycle: oe=1, dir_en=0, bus = captured load value. Then go to TA1.
  - TA1, TA_CYCLES cycles: oe=0, dir_en=0, bus floats. Then go to READ.
  - READ, RD_CYCLES+1 cycles: oe=0, dir_en=1.
    - Cycle 0 is a settle cycle: no sample is taken.
    - Cycles 1..RD_CYCLES: register bidir into smp_data and pulse smp_valid.
    - Then go to TA2.
  - TA2, TA_CYCLES cycles: oe=0, dir_en=0. Then go to DONE.
  - DONE, 1 cycle: done=1. Then go to IDLE. busy drops in the same cycle done pulses.
- Handshake: start is ignored outside IDLE. start held high in IDLE begins a new transaction immediately after DONE.
- Sequence check, for samples k>=2: sample k must equal (sample k-1 + 1) mod 2^WIDTH.
  - Sample 1 is the baseline and is not checked.
  - Wrap from 2^WIDTH-1 to 0 is legal.
  - A mismatch sets err on the cycle after the offending sample. err stays set until the next accepted start.
- X or Z sampled on the bus is treated as a mismatch when the check is compiled in.
- Arithmetic is unsigned, WIDTH bits, and truncating.

Optional Feature:
- Macro BIDIR_BUS_CTRL_SEQ_CHK_EN.
- Defined: the sequence checker and err logic are compiled in, as described above.
- Undefined: no comparator and no previous-sample register are built; err is tied to 0. Sampling, smp_valid and done are unchanged.

Test Plan:
- Basic load and read, with a counter model that loads on en=0 and increments each clk when en=1:
  - Stimulus: load_val=5, start pulse.
  - Required: bus=5 during DRIVE; bus Z during TA1; 8 smp_valid pulses with strictly consecutive smp_data; done pulses once; err=0.
- Wrap-around:
  - Stimulus: load_val=30.
  - Required: samples cross 31 -> 0 -> 1 with no err; done pulses once.
- Error injection:
  - Stimulus: the model skips one value mid-window (e.g. 9 -> 11).
  - Required: err=1 on the cycle after the bad sample, held through done and into IDLE.
  - Next start clears err.
- Busy protection:
  - Stimulus: start pulse during READ, with load_val=15.
  - Required: ignored; the current transaction completes with the original load value; exactly one done.
- Reset mid-transaction:
  - Stimulus: rst low during READ.
  - Required: immediately bidir=Z, dir_en=0, busy=0, err=0; no done pulse.
  - After rst high, a new start with load_val=6 runs normally.
- Bus contention monitor:
  - Stimulus: full run with TA_CYCLES=2.
  - Required: dir_en and oe are never both 1; bidir is Z for exactly 2 cycles at each turnaround.

Source files
------------

// File: rtl/bidir_bus_ctrl.sv
// Bus-side controller for the shared bidirectional counter bus: load, turn around, sample.
// Latency: accepted start -> done pulse = 1 (DRIVE) + TA + (RD+1) + TA + 1 (DONE) cycles.
// Backpressure: none; start is honoured only in IDLE and ignored while a transaction runs.
//
// Optional build macro: BIDIR_BUS_CTRL_SEQ_CHK_EN compiles in the +1 sequence checker
// that drives err; without it err is tied low and no checker state is built.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   start, load_val   host request and the value to load into the counter
//   busy, done, err   host status: in-flight, end-of-transaction pulse, sticky sequence error
//   dir_en            to counter en: 0 = controller side owns bus, 1 = counter drives
//   bidir             shared bus, driven with the load register only while oe is high
//   smp_data          last sampled bus value
//   smp_valid         one-cycle pulse per checked sample
module bidir_bus_ctrl #(
    parameter int WIDTH     = 5,
    parameter int RD_CYCLES = 8,
    parameter int TA_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    output logic             busy,
    output logic             dir_en,
    inout  wire  [WIDTH-1:0] bidir,
    output logic [WIDTH-1:0] smp_data,
    output logic             smp_valid,
    output logic             done,
    output logic             err
);

    // Counter has to reach RD_CYCLES (READ) and TA_CYCLES-1 (turnarounds).
    localparam int CNT_W = $clog2(RD_CYCLES + TA_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRIVE = 3'd1,
        TA1   = 3'd2,
        READ  = 3'd3,
        TA2   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   load_q;
    logic               oe_q;
    logic               dir_en_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   smp_data_q;
    logic               smp_valid_q;
    logic               accept;
    logic               take;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        take    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                cnt_d   = '0;
                state_d = TA1;
            end
            TA1: begin
                if (cnt_q == CNT_W'(TA_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = READ;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            READ: begin
                // READ cycle 0 lets the counter's driver settle; no sample there.
                take = (cnt_q != '0);
                if (cnt_q == CNT_W'(RD_CYCLES)) begin
                    cnt_d   = '0;
                    state_d = TA2;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            TA2: begin
                if (cnt_q == CNT_W'(TA_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered outputs. Outputs are loaded from state_d so they
    // line up with the state they belong to; since state_d is a single value,
    // oe and dir_en can never be high together.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            load_q      <= '0;
            oe_q        <= 1'b0;
            dir_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            smp_data_q  <= '0;
            smp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            oe_q        <= (state_d == DRIVE);
            dir_en_q    <= (state_d == READ);
            busy_q      <= (state_d != IDLE) && (state_d != DONE);
            done_q      <= (state_d == DONE);
            smp_valid_q <= take;
            if (accept) begin
                load_q <= load_val;
            end
            if (take) begin
                smp_data_q <= bidir;
            end
        end
    end

    assign bidir     = oe_q ? load_q : {WIDTH{1'bz}};
    assign busy      = busy_q;
    assign dir_en    = dir_en_q;
    assign done      = done_q;
    assign smp_data  = smp_data_q;
    assign smp_valid = smp_valid_q;

`ifdef BIDIR_BUS_CTRL_SEQ_CHK_EN
    // ------------------------------------------------------------------
    // Sequence checker: works one cycle behind the sample register, so a bad
    // sample shows on err the cycle after its smp_valid pulse. The first
    // sample of a window only arms the checker as the baseline.
    // ------------------------------------------------------------------
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] prev_q;
    logic             armed_q;
    logic             err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q  <= '0;
            armed_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (accept) begin
            armed_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (smp_valid_q) begin
            prev_q  <= smp_data_q;
            armed_q <= 1'b1;
            // Case inequality so an X/Z sample counts as a mismatch.
            if (armed_q && (smp_data_q !== (prev_q + ONE))) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
module tb_bidir_bus_ctrl;

    localparam int W  = 5;
    localparam int RD = 8;
    localparam int TA = 2;

`ifdef BIDIR_BUS_CTRL_SEQ_CHK_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    logic         clk      = 1'b0;
    logic         rst      = 1'b0;
    logic         start    = 1'b0;
    logic [W-1:0] load_val = '0;
    wire          busy;
    wire          dir_en;
    wire  [W-1:0] bidir;
    wire  [W-1:0] smp_data;
    wire          smp_valid;
    wire          done;
    wire          err;

    int checks   = 0;
    int failures = 0;

    // Counter model: loads from the bus while en=0 and the controller drives,
    // increments each clock while en=1; skip_en makes it jump 9 -> 11.
    logic [W-1:0] m_cnt   = '0;
    logic         skip_en = 1'b0;

    always #5 clk = ~clk;

    assign bidir = dir_en ? m_cnt : {W{1'bz}};
    wire bus_z = (bidir === 5'bzzzzz);

    always @(posedge clk) begin
        if (dir_en)
            m_cnt <= (skip_en && m_cnt == 5'd9) ? 5'd11 : m_cnt + 5'd1;
        else if (!bus_z)
            m_cnt <= bidir;
    end

    bidir_bus_ctrl #(.WIDTH(W), .RD_CYCLES(RD), .TA_CYCLES(TA)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .load_val (load_val),
        .busy     (busy),
        .dir_en   (dir_en),
        .bidir    (bidir),
        .smp_data (smp_data),
        .smp_valid(smp_valid),
        .done     (done),
        .err      (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction, sampled at negedges. mid_start pulses start with
    // load_val=15 in the middle of READ; it must have no effect.
    task automatic run_txn(input logic [W-1:0] lv, input bit skip, input bit mid_start);
        int           n_smp;
        int           n_done;
        int           n_z;
        bit           err_exp;
        bit           mid_sent;
        logic [W-1:0] e;
        n_smp    = 0;
        n_done   = 0;
        n_z      = 0;
        err_exp  = 1'b0;
        mid_sent = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        load_val = lv;
        skip_en  = skip;
        @(negedge clk);                       // DRIVE
        start = 1'b0;
        chk("drive_bus", bidir, lv);
        chk("drive_dir_en", dir_en, 0);
        chk("drive_busy", busy, 1);
        chk("drive_err_clr", err, 0);
        chk("drive_contention", dir_en & dut.oe_q, 0);
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 0) chk("ta1_bus_z", bus_z, 1);
            chk("contention", dir_en & dut.oe_q, 0);
            chk("err_track", err, err_exp);
            if (!dir_en && busy && bus_z) n_z++;
            if (smp_valid) begin
                e = W'(lv + 1 + n_smp);
                if (skip && n_smp >= 4) e = e + 5'd1;
                chk("smp_data", smp_data, e);
                if (skip && n_smp == 4 && CHK_ON) err_exp = 1'b1;
                n_smp++;
            end
            if (mid_start && !mid_sent && n_smp == 3) begin
                start    = 1'b1;
                load_val = 5'd15;
                mid_sent = 1'b1;
            end
            if (done) begin
                n_done++;
                chk("done_busy_low", busy, 0);
                break;
            end
        end
        chk("smp_count", n_smp, RD);
        chk("done_count", n_done, 1);
        chk("turnaround_z_cycles", n_z, 2 * TA);
        @(negedge clk);                       // back in IDLE
        chk("idle_done_low", done, 0);
        chk("idle_busy_low", busy, 0);
        chk("idle_bus_z", bus_z, 1);
        chk("idle_err_held", err, err_exp);
        skip_en = 1'b0;
    endtask

    initial begin
        int n;
        // Reset state
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_dir_en", dir_en, 0);
        chk("rst_bus_z", bus_z, 1);
        chk("rst_smp_data", smp_data, 0);
        chk("rst_smp_valid", smp_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Basic load/read: samples 6..13
        run_txn(5'd5, 1'b0, 1'b0);
        // Wrap: samples 31,0,1,...,6
        run_txn(5'd30, 1'b0, 1'b0);
        // Error injection: samples 6,7,8,9,11,12,13,14; err sticky
        run_txn(5'd5, 1'b1, 1'b0);
        // Busy protection (also shows the new start clears err)
        run_txn(5'd5, 1'b0, 1'b1);

        // Reset mid-transaction, after the skipped value has been sampled
        @(negedge clk);
        start    = 1'b1;
        load_val = 5'd5;
        skip_en  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 30 && n < 6; cyc++) begin
            @(negedge clk);
            if (smp_valid) n++;
        end
        chk("rst_mid_reached_read", n, 6);
        chk("rst_mid_pre_dir_en", dir_en, 1);
        chk("rst_mid_pre_err", err, CHK_ON);
        rst = 1'b0;
        #1;
        chk("rst_mid_bus_z", bus_z, 1);
        chk("rst_mid_dir_en", dir_en, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_err", err, 0);
        chk("rst_mid_smp_valid", smp_valid, 0);
        skip_en = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (cyc == 2) rst = 1'b1;
            if (done) n++;
        end
        chk("rst_mid_no_done", n, 0);
        chk("rst_mid_idle_busy", busy, 0);

        // Normal run after reset: samples 7..14
        run_txn(5'd6, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
